alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issues operation requests to a combinational 16-bit ALU and returns the result over a
// valid/ready response channel; 32-bit ADD/SUB are performed as two chained passes.
module alu_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_op_i,
  input  logic [2*WIDTH-1:0]   req_a_i,
  input  logic [2*WIDTH-1:0]   req_b_i,
  input  logic                 req_cin_i,
  output logic [WIDTH-1:0]     alu_x_o,
  output logic [WIDTH-1:0]     alu_y_o,
  output logic [2:0]           alu_c_o,
  output logic                 alu_cin_o,
  input  logic [WIDTH-1:0]     alu_z_i,
  input  logic                 alu_cout_i,
  input  logic                 alu_lt_i,
  input  logic                 alu_eq_i,
  input  logic                 alu_gt_i,
  input  logic                 alu_ovf_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [2*WIDTH-1:0]   rsp_z_o,
  output logic                 rsp_cout_o,
  output logic                 rsp_ovf_o,
  output logic                 rsp_lt_o,
  output logic                 rsp_eq_o,
  output logic                 rsp_gt_o,
  output logic                 rsp_err_o,
  output logic [1:0]           state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // rsp_valid and every rsp_* output stay stable from assertion until that transfer.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LO = 2'd1, S_HI = 2'd2, S_RESP = 2'd3} state_t;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_ADD32 = 3'b100;
  localparam logic [2:0] OP_SUB32 = 3'b101;
  localparam logic [2:0] OP_RSV   = 3'b110;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                 cin_q, cin_d;
  logic                 carry_lo_q, carry_lo_d;
  logic [WIDTH-1:0]     lo_z_q, lo_z_d;
  logic                 lo_lt_q, lo_lt_d, lo_eq_q, lo_eq_d, lo_gt_q, lo_gt_d;
  logic [2*WIDTH-1:0]   rsp_z_q, rsp_z_d;
  logic                 rsp_cout_q, rsp_cout_d, rsp_ovf_q, rsp_ovf_d;
  logic                 rsp_lt_q, rsp_lt_d, rsp_eq_q, rsp_eq_d, rsp_gt_q, rsp_gt_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [2*WIDTH-1:0]   z_full;
  logic                 z_zero;

  assign z_full = {alu_z_i, lo_z_q};
  assign z_zero = (z_full == '0);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    carry_lo_d = carry_lo_q;
    lo_z_d     = lo_z_q;
    lo_lt_d    = lo_lt_q;
    lo_eq_d    = lo_eq_q;
    lo_gt_d    = lo_gt_q;
    rsp_z_d    = rsp_z_q;
    rsp_cout_d = rsp_cout_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_lt_d   = rsp_lt_q;
    rsp_eq_d   = rsp_eq_q;
    rsp_gt_d   = rsp_gt_q;
    rsp_err_d  = rsp_err_q;
    alu_x_o    = '0;
    alu_y_o    = '0;
    alu_c_o    = 3'b000;
    alu_cin_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d       = req_op_i;
          a_d        = req_a_i;
          b_d        = req_b_i;
          cin_d      = req_cin_i;
          rsp_z_d    = '0;
          rsp_cout_d = 1'b0;
          rsp_ovf_d  = 1'b0;
          rsp_lt_d   = 1'b0;
          rsp_eq_d   = 1'b0;
          rsp_gt_d   = 1'b0;
          rsp_err_d  = (req_op_i == OP_RSV);
          state_d    = (req_op_i == OP_RSV) ? S_RESP : S_LO;
        end
      end

      S_LO: begin
        alu_x_o = a_q[WIDTH-1:0];
        alu_y_o = b_q[WIDTH-1:0];
        if (op_q == OP_ADD32 || op_q == OP_SUB32) begin
          // The ALU subtract code has no borrow-in, so the chained subtract is a + ~b + 1.
          alu_c_o    = OP_ADD;
          alu_y_o    = (op_q == OP_SUB32) ? ~b_q[WIDTH-1:0] : b_q[WIDTH-1:0];
          alu_cin_o  = (op_q == OP_SUB32) ? 1'b1 : cin_q;
          carry_lo_d = alu_cout_i;
          lo_z_d     = alu_z_i;
          lo_lt_d    = alu_lt_i;
          lo_eq_d    = alu_eq_i;
          lo_gt_d    = alu_gt_i;
          state_d    = S_HI;
        end else begin
          alu_c_o    = op_q;
          alu_cin_o  = (op_q == OP_ADD) ? cin_q : 1'b0;
          rsp_z_d    = {{WIDTH{1'b0}}, alu_z_i};
          rsp_cout_d = (op_q == OP_ADD || op_q == OP_SUB) ? alu_cout_i : 1'b0;
          rsp_ovf_d  = (op_q == OP_ADD || op_q == OP_SUB) ? alu_ovf_i : 1'b0;
          rsp_lt_d   = alu_lt_i;
          rsp_eq_d   = alu_eq_i;
          rsp_gt_d   = alu_gt_i;
          state_d    = S_RESP;
        end
      end

      S_HI: begin
        alu_c_o    = OP_ADD;
        alu_x_o    = a_q[2*WIDTH-1:WIDTH];
        alu_y_o    = (op_q == OP_SUB32) ? ~b_q[2*WIDTH-1:WIDTH] : b_q[2*WIDTH-1:WIDTH];
        alu_cin_o  = carry_lo_q;
        rsp_z_d    = z_full;
        rsp_cout_d = alu_cout_i;
        rsp_ovf_d  = alu_ovf_i;
        if (op_q == OP_SUB32) begin
          // Compare flags are meaningless with an inverted y; derive them from borrow and zero.
          rsp_eq_d = z_zero;
          rsp_lt_d = ~alu_cout_i;
          rsp_gt_d = alu_cout_i & ~z_zero;
        end else begin
          rsp_eq_d = alu_eq_i & lo_eq_q;
          rsp_lt_d = alu_lt_i | (alu_eq_i & lo_lt_q);
          rsp_gt_d = alu_gt_i | (alu_eq_i & lo_gt_q);
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 3'b000;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      carry_lo_q <= 1'b0;
      lo_z_q     <= '0;
      lo_lt_q    <= 1'b0;
      lo_eq_q    <= 1'b0;
      lo_gt_q    <= 1'b0;
      rsp_z_q    <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_lt_q   <= 1'b0;
      rsp_eq_q   <= 1'b0;
      rsp_gt_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      carry_lo_q <= carry_lo_d;
      lo_z_q     <= lo_z_d;
      lo_lt_q    <= lo_lt_d;
      lo_eq_q    <= lo_eq_d;
      lo_gt_q    <= lo_gt_d;
      rsp_z_q    <= rsp_z_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_lt_q   <= rsp_lt_d;
      rsp_eq_q   <= rsp_eq_d;
      rsp_gt_q   <= rsp_gt_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_z_o     = rsp_z_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign rsp_ovf_o   = rsp_ovf_q;
  assign rsp_lt_o    = rsp_lt_q;
  assign rsp_eq_o    = rsp_eq_q;
  assign rsp_gt_o    = rsp_gt_q;
  assign rsp_err_o   = rsp_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 16-bit ALU attached to its ALU port.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        req_cin = 1'b0;
  logic [15:0] alu_x, alu_y, alu_z;
  logic [2:0]  alu_c;
  logic        alu_cin, alu_cout, alu_lt, alu_eq, alu_gt, alu_ovf;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_z;
  logic        rsp_cout, rsp_ovf, rsp_lt, rsp_eq, rsp_gt, rsp_err;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  alu_op_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_cin_i(req_cin),
    .alu_x_o(alu_x), .alu_y_o(alu_y), .alu_c_o(alu_c), .alu_cin_o(alu_cin),
    .alu_z_i(alu_z), .alu_cout_i(alu_cout), .alu_lt_i(alu_lt), .alu_eq_i(alu_eq),
    .alu_gt_i(alu_gt), .alu_ovf_i(alu_ovf),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_z_o(rsp_z),
    .rsp_cout_o(rsp_cout), .rsp_ovf_o(rsp_ovf), .rsp_lt_o(rsp_lt), .rsp_eq_o(rsp_eq),
    .rsp_gt_o(rsp_gt), .rsp_err_o(rsp_err), .state_o(state)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural ALU; logic ops deliberately drive cout/ovf high to expose stale-flag leakage.
  logic [16:0] sum17, diff17;
  always_comb begin
    sum17    = {1'b0, alu_x} + {1'b0, alu_y} + {16'd0, alu_cin};
    diff17   = {1'b0, alu_x} - {1'b0, alu_y};
    alu_lt   = (alu_x < alu_y);
    alu_eq   = (alu_x == alu_y);
    alu_gt   = (alu_x > alu_y);
    alu_z    = 16'h0000;
    alu_cout = 1'b1;
    alu_ovf  = 1'b1;
    case (alu_c)
      3'b000: alu_z = alu_x & alu_y;
      3'b001: alu_z = alu_x | alu_y;
      3'b010: begin
        alu_z    = sum17[15:0];
        alu_cout = sum17[16];
        alu_ovf  = (alu_x[15] == alu_y[15]) && (sum17[15] != alu_x[15]);
      end
      3'b011: begin
        alu_z    = diff17[15:0];
        alu_cout = ~diff17[16];
        alu_ovf  = (alu_x[15] != alu_y[15]) && (diff17[15] != alu_x[15]);
      end
      3'b111: alu_z = {15'd0, alu_x < alu_y};
      default: alu_z = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return {26'd0, rsp_err, rsp_cout, rsp_ovf, rsp_lt, rsp_eq, rsp_gt};
  endfunction

  // Driver: issue one request, check latency, response fields, stall stability and handshake.
  // ef = {err, cout, ovf, lt, eq, gt}; hcin is the carry-in expected during the HI pass.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cin, input int lat,
                       input logic [31:0] ez, input logic [5:0] ef, input logic hcin,
                       input int stall);
    logic [31:0] e;
    chk({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    exp_q.push_back(ez);
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c < lat; c++) begin
      chk({tag, ".rsp_valid_early"}, 32'(rsp_valid), 32'd0);
      if (lat == 3 && c == 2) begin
        chk({tag, ".hi_alu_c"}, 32'(alu_c), 32'd2);
        chk({tag, ".hi_alu_cin"}, 32'(alu_cin), 32'(hcin));
      end
      step();
    end
    e = exp_q.pop_front();
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_z"}, rsp_z, e);
    chk({tag, ".flags"}, flags(), 32'(ef));
    chk({tag, ".alu_idle_c"}, 32'(alu_c), 32'd0);
    for (int s = 0; s < stall; s++) begin
      step();
      chk({tag, ".stall_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".stall_z"}, rsp_z, e);
      chk({tag, ".stall_flags"}, flags(), 32'(ef));
      chk({tag, ".stall_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    chk({tag, ".hs_req_ready"}, 32'(req_ready), 32'd0);
    step();
    rsp_ready = 1'b0;
    chk({tag, ".post_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".post_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset
    repeat (3) step();
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_z", rsp_z, 32'd0);
    chk("rst.flags", flags(), 32'd0);
    chk("rst.alu", {alu_x, alu_y}, 32'd0);
    chk("rst.alu_c_cin", {28'd0, alu_c, alu_cin}, 32'd0);
    chk("rst.state", 32'(state), 32'd0);
    reset = 1'b0;
    step();

    do_op("add",     3'b010, 32'd5,         32'd10,        1'b0, 2, 32'd15,        6'b000100, 1'b0, 0);
    do_op("add_cin", 3'b010, 32'hABCD_FFFF, 32'h1234_0001, 1'b1, 2, 32'h0000_0001, 6'b010001, 1'b0, 0);
    do_op("sub",     3'b011, 32'd3,         32'd5,         1'b0, 2, 32'h0000_FFFE, 6'b000100, 1'b0, 0);
    do_op("add32",   3'b100, 32'h0000_FFFF, 32'd1,         1'b0, 3, 32'h0001_0000, 6'b000001, 1'b1, 0);
    do_op("sub32a",  3'b101, 32'h8000_0000, 32'd1,         1'b0, 3, 32'h7FFF_FFFF, 6'b011001, 1'b0, 0);
    do_op("sub32b",  3'b101, 32'd1,         32'd2,         1'b0, 3, 32'hFFFF_FFFF, 6'b000100, 1'b0, 0);
    do_op("sub32eq", 3'b101, 32'h1234_5678, 32'h1234_5678, 1'b0, 3, 32'h0000_0000, 6'b010010, 1'b1, 0);
    do_op("and",     3'b000, 32'h0000_0123, 32'h0000_F1F2, 1'b1, 2, 32'h0000_0122, 6'b000100, 1'b0, 0);
    do_op("or",      3'b001, 32'h0000_0F00, 32'h0000_00F0, 1'b0, 2, 32'h0000_0FF0, 6'b000001, 1'b0, 0);
    do_op("slt",     3'b111, 32'd9,         32'd10,        1'b0, 2, 32'h0000_0001, 6'b000100, 1'b0, 0);
    do_op("add32st", 3'b100, 32'h7FFF_FFFF, 32'd1,         1'b0, 3, 32'h8000_0000, 6'b001001, 1'b1, 5);
    do_op("rsv",     3'b110, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1, 32'h0000_0000, 6'b100000, 1'b0, 0);

    // Reset while the SUB32 high pass is on the ALU
    req_op = 3'b101; req_a = 32'h0001_0000; req_b = 32'h0000_0001; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("mid.state_hi", 32'(state), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid.req_ready", 32'(req_ready), 32'd1);
    chk("mid.alu_c", 32'(alu_c), 32'd0);
    chk("mid.rsp_z", rsp_z, 32'd0);
    do_op("add_after_rst", 3'b010, 32'd1, 32'd1, 1'b0, 2, 32'd2, 6'b000010, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
